pipe_hazard_tracker: RTL and testbench

PIPE_HAZARD_TRACKER -- requirements
Module: pipe_hazard_tracker

---
 rtl/pipe_hazard_tracker_pkg.sv | 50 +++++
 rtl/pipe_hazard_tracker_stage_reg.sv | 39 +++
 rtl/pipe_hazard_tracker.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_tracker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared instruction-class encoding, bubble encoding and class predicates
// for the hazard tracker, forwarding and decode logic.
package pipe_hazard_tracker_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TYPE_W = 3;

    typedef enum logic [TYPE_W-1:0] {
        T_I_LOAD  = 3'b000,
        T_I_LOGIC = 3'b001,
        T_S       = 3'b010,
        T_R       = 3'b011,
        T_J       = 3'b100,
        T_U       = 3'b101,
        T_I_JUMP  = 3'b110,
        T_B       = 3'b111
    } instr_type_e;

    // A bubble is a store with all register fields zero, so it never writes rd
    localparam logic [REG_W-1:0]  BUBBLE_REG  = 5'd0;
    localparam logic [TYPE_W-1:0] BUBBLE_TYPE = 3'b010;

    function automatic logic writes_rd(input logic [TYPE_W-1:0] t);
        logic res;
        case (instr_type_e'(t))
            T_R, T_U, T_I_LOGIC, T_I_LOAD, T_J, T_I_JUMP: res = 1'b1;
            default:                                      res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic uses_r1(input logic [TYPE_W-1:0] t);
        logic res;
        case (instr_type_e'(t))
            T_U, T_J: res = 1'b0;
            default:  res = 1'b1;
        endcase
        return res;
    endfunction

    function automatic logic uses_r2(input logic [TYPE_W-1:0] t);
        logic res;
        case (instr_type_e'(t))
            T_R, T_S, T_B: res = 1'b1;
            default:       res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pipe_hazard_tracker_stage_reg.sv
// Pipeline stage register holding N_FIELDS register numbers plus a type code.
// The last (least significant) field is rd; a bubble clears every field.
module pipe_stage_reg
    import pipe_hazard_tracker_pkg::*;
#(
    parameter int unsigned N_FIELDS = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_bubble,
    input  logic [N_FIELDS*REG_W-1:0]    fields_d,
    input  logic [TYPE_W-1:0]            type_d,
    output logic [N_FIELDS*REG_W-1:0]    fields_q,
    output logic [TYPE_W-1:0]            type_q
);

    localparam int unsigned FW = N_FIELDS * REG_W;

    logic [FW-1:0]     fields_r;
    logic [TYPE_W-1:0] type_r;

    // Stage contents: bubble on reset or request, otherwise capture the inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fields_r <= {FW{1'b0}};
            type_r   <= BUBBLE_TYPE;
        end else if (load_bubble) begin
            fields_r <= {FW{1'b0}};
            type_r   <= BUBBLE_TYPE;
        end else begin
            fields_r <= fields_d;
            type_r   <= type_d;
        end
    end

    assign fields_q = fields_r;
    assign type_q   = type_r;

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Tracks rd/type through ID_EX, EX_MEM and MEM_WB, detects load-use hazards
// in ID, inserts one-cycle bubbles and counts stall cycles (saturating).
module pipe_hazard_tracker
    import pipe_hazard_tracker_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [4:0]             id_r1,
    input  logic [4:0]             id_r2,
    input  logic [4:0]             id_rd,
    input  logic [2:0]             id_type,
    input  logic                   flush,
    output logic                   stall,
    output logic [4:0]             ID_EX_r1,
    output logic [4:0]             ID_EX_r2,
    output logic [4:0]             ID_EX_rd,
    output logic [2:0]             ID_EX_type,
    output logic [4:0]             EX_MEM_rd,
    output logic [2:0]             EX_MEM_type,
    output logic [4:0]             MEM_WB_rd,
    output logic [2:0]             MEM_WB_type,
    output logic                   wb_we,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [3*REG_W-1:0]     id_ex_fields_s;
    logic [TYPE_W-1:0]      id_ex_type_s;
    logic [REG_W-1:0]       ex_mem_rd_s;
    logic [TYPE_W-1:0]      ex_mem_type_s;
    logic [REG_W-1:0]       mem_wb_rd_s;
    logic [TYPE_W-1:0]      mem_wb_type_s;
    logic                   hazard_s;
    logic                   stall_s;
    logic                   id_ex_bubble_s;
    logic                   wb_we_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    // Load-use detection against the instruction currently in ID_EX
    always_comb begin
        hazard_s = 1'b0;
        if (id_valid && (id_ex_type_s == T_I_LOAD) && (id_ex_fields_s[REG_W-1:0] != 5'd0)) begin
            hazard_s = (uses_r1(id_type) && (id_r1 == id_ex_fields_s[REG_W-1:0])) ||
                       (uses_r2(id_type) && (id_r2 == id_ex_fields_s[REG_W-1:0]));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Flush wins over the hazard: the ID instruction is discarded anyway
    always_comb begin
        stall_s        = 1'b0;
        id_ex_bubble_s = 1'b1;
        if (flush) begin
            stall_s        = 1'b0;
            id_ex_bubble_s = 1'b1;
        end else if (hazard_s) begin
            stall_s        = 1'b1;
            id_ex_bubble_s = 1'b1;
        end else begin
            stall_s        = 1'b0;
            id_ex_bubble_s = !id_valid;
        end
    end

    pipe_stage_reg #(.N_FIELDS(3)) u_id_ex (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_bubble (id_ex_bubble_s),
        .fields_d    ({id_r1, id_r2, id_rd}),
        .type_d      (id_type),
        .fields_q    (id_ex_fields_s),
        .type_q      (id_ex_type_s)
    );

    pipe_stage_reg #(.N_FIELDS(1)) u_ex_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_bubble (1'b0),
        .fields_d    (id_ex_fields_s[REG_W-1:0]),
        .type_d      (id_ex_type_s),
        .fields_q    (ex_mem_rd_s),
        .type_q      (ex_mem_type_s)
    );

    pipe_stage_reg #(.N_FIELDS(1)) u_mem_wb (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_bubble (1'b0),
        .fields_d    (ex_mem_rd_s),
        .type_d      (ex_mem_type_s),
        .fields_q    (mem_wb_rd_s),
        .type_q      (mem_wb_type_s)
    );

    // Write enable travels alongside the EX_MEM -> MEM_WB transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_r <= 1'b0;
        end else begin
            wb_we_r <= writes_rd(ex_mem_type_s) && (ex_mem_rd_s != 5'd0);
        end
    end

    // Saturating count of load-use stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall       = stall_s;
    assign ID_EX_r1    = id_ex_fields_s[3*REG_W-1:2*REG_W];
    assign ID_EX_r2    = id_ex_fields_s[2*REG_W-1:REG_W];
    assign ID_EX_rd    = id_ex_fields_s[REG_W-1:0];
    assign ID_EX_type  = id_ex_type_s;
    assign EX_MEM_rd   = ex_mem_rd_s;
    assign EX_MEM_type = ex_mem_type_s;
    assign MEM_WB_rd   = mem_wb_rd_s;
    assign MEM_WB_type = mem_wb_type_s;
    assign wb_we       = wb_we_r;
    assign stall_count = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Directed table-driven bench for pipe_hazard_tracker plus hand-written
// sequences for saturation (2-bit counter instance) and mid-stall reset.
module tb_pipe_hazard_tracker;

    localparam logic [2:0] LD = 3'b000, LG = 3'b001, S = 3'b010, R = 3'b011,
                           J  = 3'b100, U  = 3'b101, IJ = 3'b110, B = 3'b111;

    typedef struct {
        logic       v;
        logic [2:0] ty;
        logic [4:0] r1, r2, rd;
        logic       fl;
        logic       e_stall;
        logic [4:0] e_ir1, e_ir2, e_ird;
        logic [2:0] e_ity;
        logic [4:0] e_emrd;
        logic [2:0] e_emty;
        logic [4:0] e_mwrd;
        logic [2:0] e_mwty;
        logic       e_we;
        logic [15:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, flush;
    logic [4:0]  id_r1, id_r2, id_rd;
    logic [2:0]  id_type;
    logic        stall, s_stall;
    logic [4:0]  ID_EX_r1, ID_EX_r2, ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
    logic [2:0]  ID_EX_type, EX_MEM_type, MEM_WB_type;
    logic        wb_we, s_wb_we;
    logic [15:0] stall_count;
    logic [4:0]  s_id_ex_r1, s_id_ex_r2, s_id_ex_rd, s_ex_mem_rd, s_mem_wb_rd;
    logic [2:0]  s_id_ex_type, s_ex_mem_type, s_mem_wb_type;
    logic [1:0]  s_stall_count;

    int   n_applied = 0;
    int   n_miss    = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_hazard_tracker dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
        .id_rd(id_rd), .id_type(id_type), .flush(flush), .stall(stall),
        .ID_EX_r1(ID_EX_r1), .ID_EX_r2(ID_EX_r2), .ID_EX_rd(ID_EX_rd), .ID_EX_type(ID_EX_type),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_type(EX_MEM_type), .MEM_WB_rd(MEM_WB_rd),
        .MEM_WB_type(MEM_WB_type), .wb_we(wb_we), .stall_count(stall_count)
    );

    pipe_hazard_tracker #(.STALL_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
        .id_rd(id_rd), .id_type(id_type), .flush(flush), .stall(s_stall),
        .ID_EX_r1(s_id_ex_r1), .ID_EX_r2(s_id_ex_r2), .ID_EX_rd(s_id_ex_rd),
        .ID_EX_type(s_id_ex_type), .EX_MEM_rd(s_ex_mem_rd), .EX_MEM_type(s_ex_mem_type),
        .MEM_WB_rd(s_mem_wb_rd), .MEM_WB_type(s_mem_wb_type), .wb_we(s_wb_we),
        .stall_count(s_stall_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [2:0] ty, input logic [4:0] r1, r2, rd,
                       input logic fl, input logic es,
                       input logic [4:0] ir1, ir2, ird, input logic [2:0] ity,
                       input logic [4:0] emrd, input logic [2:0] emty,
                       input logic [4:0] mwrd, input logic [2:0] mwty,
                       input logic we, input logic [15:0] cnt);
        vec_t x;
        x.v = v; x.ty = ty; x.r1 = r1; x.r2 = r2; x.rd = rd; x.fl = fl; x.e_stall = es;
        x.e_ir1 = ir1; x.e_ir2 = ir2; x.e_ird = ird; x.e_ity = ity;
        x.e_emrd = emrd; x.e_emty = emty; x.e_mwrd = mwrd; x.e_mwty = mwty;
        x.e_we = we; x.e_cnt = cnt;
        vecs.push_back(x);
    endtask

    // Drive at the falling edge, sample stall before the rising edge, return just after it
    task automatic step_io(input logic v, input logic [2:0] ty, input logic [4:0] r1, r2, rd,
                           input logic fl, output logic st);
        @(negedge clk);
        id_valid = v; id_type = ty; id_r1 = r1; id_r2 = r2; id_rd = rd; flush = fl;
        #1 st = stall;
        @(posedge clk);
        #1;
        n_applied++;
    endtask

    task automatic check_bubble(input string tag);
        chk({tag, " ID_EX_r1"}, 32'(ID_EX_r1), 32'd0);
        chk({tag, " ID_EX_r2"}, 32'(ID_EX_r2), 32'd0);
        chk({tag, " ID_EX_rd"}, 32'(ID_EX_rd), 32'd0);
        chk({tag, " ID_EX_type"}, 32'(ID_EX_type), 32'(S));
        chk({tag, " EX_MEM_rd"}, 32'(EX_MEM_rd), 32'd0);
        chk({tag, " EX_MEM_type"}, 32'(EX_MEM_type), 32'(S));
        chk({tag, " MEM_WB_rd"}, 32'(MEM_WB_rd), 32'd0);
        chk({tag, " MEM_WB_type"}, 32'(MEM_WB_type), 32'(S));
        chk({tag, " wb_we"}, 32'(wb_we), 32'd0);
        chk({tag, " stall"}, 32'(stall), 32'd0);
        chk({tag, " stall_count"}, 32'(stall_count), 32'd0);
        chk({tag, " sat stall_count"}, 32'(s_stall_count), 32'd0);
    endtask

    initial begin
        logic st;
        //   v  ty  r1 r2 rd fl st | ID_EX r1 r2 rd ty | EMrd EMty | MWrd MWty | we cnt
        add(1'b1, LD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5, LD, 5'd0, S,  5'd0, S,  1'b0, 16'd0);
        add(1'b1, R,  5'd5, 5'd7, 5'd8, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, S,  5'd5, LD, 5'd0, S,  1'b0, 16'd1);
        add(1'b1, R,  5'd5, 5'd7, 5'd8, 1'b0, 1'b0, 5'd5, 5'd7, 5'd8, R,  5'd0, S,  5'd5, LD, 1'b1, 16'd1);
        add(1'b1, LD, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 5'd0, 5'd0, LD, 5'd8, R,  5'd0, S,  1'b0, 16'd1);
        add(1'b1, R,  5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6, R,  5'd0, LD, 5'd8, R,  1'b1, 16'd1);
        add(1'b1, LD, 5'd1, 5'd0, 5'd3, 1'b0, 1'b0, 5'd1, 5'd0, 5'd3, LD, 5'd6, R,  5'd0, LD, 1'b0, 16'd1);
        add(1'b1, U,  5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 5'd3, 5'd3, 5'd3, U,  5'd3, LD, 5'd6, R,  1'b1, 16'd1);
        add(1'b1, LD, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, LD, 5'd3, U,  5'd3, LD, 1'b1, 16'd1);
        add(1'b1, R,  5'd4, 5'd0, 5'd1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, S,  5'd4, LD, 5'd3, U,  1'b1, 16'd1);
        add(1'b1, LG, 5'd1, 5'd0, 5'd9, 1'b0, 1'b0, 5'd1, 5'd0, 5'd9, LG, 5'd0, S,  5'd4, LD, 1'b1, 16'd1);
        add(1'b1, B,  5'd2, 5'd3, 5'd9, 1'b0, 1'b0, 5'd2, 5'd3, 5'd9, B,  5'd9, LG, 5'd0, S,  1'b0, 16'd1);
        add(1'b0, LD, 5'd9, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, S,  5'd9, B,  5'd9, LG, 1'b1, 16'd1);
        add(1'b0, LD, 5'd9, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, S,  5'd0, S,  5'd9, B,  1'b0, 16'd1);
        add(1'b1, LD, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, LD, 5'd0, S,  5'd0, S,  1'b0, 16'd1);
        add(1'b1, S,  5'd1, 5'd7, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, S,  5'd7, LD, 5'd0, S,  1'b0, 16'd2);
        add(1'b1, S,  5'd1, 5'd7, 5'd0, 1'b0, 1'b0, 5'd1, 5'd7, 5'd0, S,  5'd0, S,  5'd7, LD, 1'b1, 16'd2);
        add(1'b1, LD, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, LD, 5'd0, S,  5'd0, S,  1'b0, 16'd2);
        add(1'b0, R,  5'd2, 5'd0, 5'd1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, S,  5'd2, LD, 5'd0, S,  1'b0, 16'd2);

        // Reset held with a valid instruction presented in ID
        rst_n = 1'b0;
        id_valid = 1'b1; id_type = LD; id_r1 = 5'd1; id_r2 = 5'd0; id_rd = 5'd5; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_bubble("reset");
        n_applied++;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step_io(vecs[i].v, vecs[i].ty, vecs[i].r1, vecs[i].r2, vecs[i].rd, vecs[i].fl, st);
            chk($sformatf("v%0d stall", i), 32'(st), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d ID_EX_r1", i), 32'(ID_EX_r1), 32'(vecs[i].e_ir1));
            chk($sformatf("v%0d ID_EX_r2", i), 32'(ID_EX_r2), 32'(vecs[i].e_ir2));
            chk($sformatf("v%0d ID_EX_rd", i), 32'(ID_EX_rd), 32'(vecs[i].e_ird));
            chk($sformatf("v%0d ID_EX_type", i), 32'(ID_EX_type), 32'(vecs[i].e_ity));
            chk($sformatf("v%0d EX_MEM_rd", i), 32'(EX_MEM_rd), 32'(vecs[i].e_emrd));
            chk($sformatf("v%0d EX_MEM_type", i), 32'(EX_MEM_type), 32'(vecs[i].e_emty));
            chk($sformatf("v%0d MEM_WB_rd", i), 32'(MEM_WB_rd), 32'(vecs[i].e_mwrd));
            chk($sformatf("v%0d MEM_WB_type", i), 32'(MEM_WB_type), 32'(vecs[i].e_mwty));
            chk($sformatf("v%0d wb_we", i), 32'(wb_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d stall_count", i), 32'(stall_count), 32'(vecs[i].e_cnt));
        end

        // Saturation: clear both instances, then force five load-use stalls
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_bubble("sat reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step_io(1'b1, LD, 5'd0, 5'd0, 5'd5, 1'b0, st);
            chk($sformatf("sat%0d load stall", k), 32'(st), 32'd0);
            step_io(1'b1, R, 5'd5, 5'd7, 5'd8, 1'b0, st);
            chk($sformatf("sat%0d use stall", k), 32'(st), 32'd1);
            chk($sformatf("sat%0d 2b count", k), 32'(s_stall_count), (k < 2) ? 32'(k + 1) : 32'd3);
            chk($sformatf("sat%0d 16b count", k), 32'(stall_count), 32'(k + 1));
        end

        // Reset asserted in the middle of a stall cycle
        step_io(1'b1, LD, 5'd0, 5'd0, 5'd6, 1'b0, st);
        @(negedge clk);
        id_valid = 1'b1; id_type = R; id_r1 = 5'd6; id_r2 = 5'd0; id_rd = 5'd3; flush = 1'b0;
        #1 chk("midrst stall before", 32'(stall), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_bubble("midrst async");
        @(posedge clk);
        #1 check_bubble("midrst held");
        n_applied++;
        rst_n = 1'b1;
        step_io(1'b1, R, 5'd6, 5'd0, 5'd3, 1'b0, st);
        chk("midrst first stall", 32'(st), 32'd0);
        chk("midrst ID_EX_r1", 32'(ID_EX_r1), 32'd6);
        chk("midrst ID_EX_rd", 32'(ID_EX_rd), 32'd3);
        chk("midrst ID_EX_type", 32'(ID_EX_type), 32'(R));
        chk("midrst stall_count", 32'(stall_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
